// File: rtl/door_run_timer.sv
// Door-cycle and one-floor run timer for an elevator car.
// A single FSM sequences the door (open, dwell, close) or a one-floor run.
// Each sequence ends with a one-cycle completion pulse. The FSM then holds
// in a release state until the controller drops its request line. Requests
// that break the handshake protocol are ignored and latch a sticky fault flag.
module door_run_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       switch,
  input  logic       opendoor,
  input  logic       mv2nxt,
  input  logic       open_btn,
  input  logic       close_btn,
  input  logic       obstruct,
  output logic       endOpen,
  output logic       endRun,
  output logic [4:0] DoorCount,
  output logic [2:0] door_pos,
  output logic [2:0] tstate,
  output logic       run_busy,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_OPENING = 3'b001,
    S_DWELL   = 3'b010,
    S_CLOSING = 3'b011,
    S_REL_D   = 3'b100,
    S_RUN     = 3'b101,
    S_REL_R   = 3'b110,
    S_BAD     = 3'b111
  } state_e;

  state_e      r_state,    w_state;
  logic [2:0]  r_door_pos, w_door_pos;
  logic [4:0]  r_door_cnt, w_door_cnt;
  logic [5:0]  r_run_cnt,  w_run_cnt;
  logic        r_end_open, w_end_open;
  logic        r_end_run,  w_end_run;
  logic        r_fault,    w_fault;

  // State register: all timer state moves together on the rising edge.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_door_pos <= 3'd0;
      r_door_cnt <= 5'd0;
      r_run_cnt  <= 6'd0;
      r_end_open <= 1'b0;
      r_end_run  <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_door_pos <= w_door_pos;
      r_door_cnt <= w_door_cnt;
      r_run_cnt  <= w_run_cnt;
      r_end_open <= w_end_open;
      r_end_run  <= w_end_run;
      r_fault    <= w_fault;
    end
  end

  // Next-state and next-register logic; switch=0 clears everything.
  // NOTE: every target gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    w_state    = r_state;
    w_door_pos = r_door_pos;
    w_door_cnt = r_door_cnt;
    w_run_cnt  = r_run_cnt;
    w_end_open = 1'b0;
    w_end_run  = 1'b0;
    w_fault    = r_fault;

    if (!switch) begin
      w_state    = S_IDLE;
      w_door_pos = 3'd0;
      w_door_cnt = 5'd0;
      w_run_cnt  = 6'd0;
      w_fault    = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (opendoor) begin
            // Door request wins; a simultaneous run request is a violation.
            if (mv2nxt) w_fault = 1'b1;
            w_state    = S_OPENING;
            w_door_pos = 3'd0;
          end else if (mv2nxt) begin
            w_state   = S_RUN;
            w_run_cnt = 6'd0;
          end
        end

        S_OPENING: begin
          if (mv2nxt) w_fault = 1'b1;
          if (r_door_pos == 3'd7) begin
            w_state    = S_DWELL;
            w_door_cnt = 5'd0;
          end else begin
            w_door_pos = r_door_pos + 3'd1;
          end
        end

        S_DWELL: begin
          if (mv2nxt) w_fault = 1'b1;
          if (obstruct) begin
            w_door_cnt = r_door_cnt;           // hold while the edge is blocked
          end else if (open_btn) begin
            w_door_cnt = 5'd0;                 // restart the dwell
          end else if (close_btn || r_door_cnt == 5'd31) begin
            w_state    = S_CLOSING;
            w_door_cnt = 5'd0;
          end else begin
            w_door_cnt = r_door_cnt + 5'd1;
          end
        end

        S_CLOSING: begin
          if (mv2nxt) w_fault = 1'b1;
          if (obstruct || open_btn) begin
            // Reverse one step; position saturates at fully open.
            w_state    = S_OPENING;
            w_door_pos = (r_door_pos == 3'd7) ? 3'd7 : r_door_pos + 3'd1;
          end else if (r_door_pos == 3'd0) begin
            w_state    = S_REL_D;
            w_end_open = 1'b1;
          end else begin
            w_door_pos = r_door_pos - 3'd1;
          end
        end

        S_REL_D: begin
          if (!opendoor) w_state = S_IDLE;
        end

        S_RUN: begin
          if (opendoor) w_fault = 1'b1;
          if (r_run_cnt == 6'd63) begin
            w_state   = S_REL_R;
            w_end_run = 1'b1;
            w_run_cnt = 6'd0;
          end else begin
            w_run_cnt = r_run_cnt + 6'd1;
          end
        end

        S_REL_R: begin
          if (!mv2nxt) w_state = S_IDLE;
        end

        default: begin
          w_state = S_IDLE;
        end
      endcase
    end
  end

  assign endOpen   = r_end_open;
  assign endRun    = r_end_run;
  assign DoorCount = r_door_cnt;
  assign door_pos  = r_door_pos;
  assign tstate    = r_state;
  assign run_busy  = (r_state == S_RUN);
  assign fault     = r_fault;

endmodule

// File: tb/tb_door_run_timer.sv
// Self-checking bench for door_run_timer: a vector table for the IDLE and
// protocol behaviour, plus hand-written multi-cycle sequences for the door
// cycle, run, reopen, early close, fault and asynchronous reset cases.
module tb_door_run_timer;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_OPENING = 3'd1;
  localparam logic [2:0] ST_DWELL   = 3'd2;
  localparam logic [2:0] ST_CLOSING = 3'd3;
  localparam logic [2:0] ST_REL_D   = 3'd4;
  localparam logic [2:0] ST_RUN     = 3'd5;
  localparam logic [2:0] ST_REL_R   = 3'd6;

  typedef struct packed {
    logic [2:0] st;
    logic [2:0] pos;
    logic [4:0] cnt;
    logic       eo;
    logic       er;
    logic       busy;
    logic       flt;
  } exp_t;

  typedef struct {
    logic sw, od, mv, ob, cb, obs;
    exp_t e;
  } vec_t;

  logic       clk, rst_n, switch, opendoor, mv2nxt, open_btn, close_btn, obstruct;
  logic       endOpen, endRun, run_busy, fault;
  logic [4:0] DoorCount;
  logic [2:0] door_pos, tstate;

  int   n_chk = 0;
  int   n_err = 0;
  logic g_flt = 1'b0;
  exp_t sb[$];
  vec_t tbl[10];

  door_run_timer dut (
    .clk(clk), .rst_n(rst_n), .switch(switch), .opendoor(opendoor),
    .mv2nxt(mv2nxt), .open_btn(open_btn), .close_btn(close_btn),
    .obstruct(obstruct), .endOpen(endOpen), .endRun(endRun),
    .DoorCount(DoorCount), .door_pos(door_pos), .tstate(tstate),
    .run_busy(run_busy), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(input logic [2:0] st, input logic [2:0] pos,
                              input logic [4:0] cnt, input logic eo,
                              input logic er, input logic flt);
    exp_t r;
    r.st   = st;
    r.pos  = pos;
    r.cnt  = cnt;
    r.eo   = eo;
    r.er   = er;
    r.busy = (st == ST_RUN);
    r.flt  = flt;
    return r;
  endfunction

  function automatic exp_t got();
    exp_t r;
    r.st   = tstate;
    r.pos  = door_pos;
    r.cnt  = DoorCount;
    r.eo   = endOpen;
    r.er   = endRun;
    r.busy = run_busy;
    r.flt  = fault;
    return r;
  endfunction

  task automatic check(input string nm, input exp_t act, input exp_t req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got st=%0d pos=%0d cnt=%0d eo=%b er=%b busy=%b flt=%b, need st=%0d pos=%0d cnt=%0d eo=%b er=%b busy=%b flt=%b",
               nm, act.st, act.pos, act.cnt, act.eo, act.er, act.busy, act.flt,
               req.st, req.pos, req.cnt, req.eo, req.er, req.busy, req.flt);
    end
  endtask

  // Push the expectation for the coming edge, clock once, pop and compare.
  task automatic exp_step(input string nm, input exp_t e);
    exp_t q;
    sb.push_back(e);
    @(posedge clk);
    #1;
    q = sb.pop_front();
    check(nm, got(), q);
  endtask

  task automatic set_in(input logic sw, input logic od, input logic mv,
                        input logic ob, input logic cb, input logic obs);
    switch    = sw;
    opendoor  = od;
    mv2nxt    = mv;
    open_btn  = ob;
    close_btn = cb;
    obstruct  = obs;
  endtask

  task automatic opening(input int p0);
    for (int p = p0; p <= 7; p++)
      exp_step($sformatf("opening pos%0d", p), mk(ST_OPENING, 3'(p), 5'd0, 1'b0, 1'b0, g_flt));
    exp_step("dwell entry", mk(ST_DWELL, 3'd7, 5'd0, 1'b0, 1'b0, g_flt));
  endtask

  task automatic dwell(input int a, input int b);
    for (int c = a; c <= b; c++)
      exp_step($sformatf("dwell cnt%0d", c), mk(ST_DWELL, 3'd7, 5'(c), 1'b0, 1'b0, g_flt));
  endtask

  task automatic closing(input int a, input int b);
    for (int p = a; p >= b; p--)
      exp_step($sformatf("closing pos%0d", p), mk(ST_CLOSING, 3'(p), 5'd0, 1'b0, 1'b0, g_flt));
  endtask

  task automatic run_cycle();
    for (int i = 0; i < 64; i++)
      exp_step($sformatf("run cyc%0d", i), mk(ST_RUN, 3'd0, 5'd0, 1'b0, 1'b0, g_flt));
    exp_step("endRun pulse", mk(ST_REL_R, 3'd0, 5'd0, 1'b0, 1'b1, g_flt));
  endtask

  initial begin
    // IDLE / protocol vectors: {sw, od, mv, ob, cb, obs} -> expected outputs.
    tbl[0] = '{1, 0, 0, 0, 0, 0, mk(ST_IDLE,    3'd0, 5'd0, 0, 0, 0)};
    tbl[1] = '{1, 0, 0, 1, 1, 1, mk(ST_IDLE,    3'd0, 5'd0, 0, 0, 0)};
    tbl[2] = '{1, 0, 1, 0, 0, 0, mk(ST_RUN,     3'd0, 5'd0, 0, 0, 0)};
    tbl[3] = '{1, 1, 1, 0, 0, 0, mk(ST_RUN,     3'd0, 5'd0, 0, 0, 1)};
    tbl[4] = '{1, 0, 1, 0, 0, 0, mk(ST_RUN,     3'd0, 5'd0, 0, 0, 1)};
    tbl[5] = '{0, 1, 1, 0, 0, 0, mk(ST_IDLE,    3'd0, 5'd0, 0, 0, 0)};
    tbl[6] = '{1, 1, 0, 0, 0, 0, mk(ST_OPENING, 3'd0, 5'd0, 0, 0, 0)};
    tbl[7] = '{1, 1, 1, 0, 0, 0, mk(ST_OPENING, 3'd1, 5'd0, 0, 0, 1)};
    tbl[8] = '{0, 1, 0, 0, 0, 0, mk(ST_IDLE,    3'd0, 5'd0, 0, 0, 0)};
    tbl[9] = '{1, 0, 0, 0, 0, 0, mk(ST_IDLE,    3'd0, 5'd0, 0, 0, 0)};

    rst_n = 1'b0;
    set_in(1, 0, 0, 0, 0, 0);
    #12;
    check("reset state", got(), mk(ST_IDLE, 3'd0, 5'd0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      set_in(tbl[i].sw, tbl[i].od, tbl[i].mv, tbl[i].ob, tbl[i].cb, tbl[i].obs);
      exp_step($sformatf("tbl[%0d]", i), tbl[i].e);
    end

    // Full door cycle; run request in REL_D must be ignored without fault.
    set_in(1, 1, 0, 0, 0, 0);
    opening(0);
    dwell(1, 31);
    closing(7, 0);
    exp_step("door endOpen", mk(ST_REL_D, 3'd0, 5'd0, 1, 0, 0));
    mv2nxt = 1'b1;
    exp_step("rel_d no repulse", mk(ST_REL_D, 3'd0, 5'd0, 0, 0, 0));
    set_in(1, 0, 0, 0, 0, 0);
    exp_step("rel_d to idle", mk(ST_IDLE, 3'd0, 5'd0, 0, 0, 0));

    // One-floor run with door buttons asserted (no effect), held 3 extra.
    set_in(1, 0, 1, 1, 1, 1);
    run_cycle();
    set_in(1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      exp_step($sformatf("rel_r hold%0d", i), mk(ST_REL_R, 3'd0, 5'd0, 0, 0, 0));
    set_in(1, 0, 0, 0, 0, 0);
    exp_step("rel_r to idle", mk(ST_IDLE, 3'd0, 5'd0, 0, 0, 0));

    // Reopen: obstruction while closing at door_pos 3.
    set_in(1, 1, 0, 0, 0, 0);
    opening(0);
    dwell(1, 31);
    closing(7, 3);
    obstruct = 1'b1;
    exp_step("reopen pos4", mk(ST_OPENING, 3'd4, 5'd0, 0, 0, 0));
    obstruct = 1'b0;
    opening(5);
    dwell(1, 31);
    closing(7, 0);
    exp_step("reopen endOpen", mk(ST_REL_D, 3'd0, 5'd0, 1, 0, 0));
    opendoor = 1'b0;
    exp_step("reopen idle", mk(ST_IDLE, 3'd0, 5'd0, 0, 0, 0));

    // Early close, with obstruct and open_btn priority over close_btn.
    set_in(1, 1, 0, 0, 0, 0);
    opening(0);
    dwell(1, 5);
    set_in(1, 1, 0, 0, 1, 1);
    exp_step("obstruct holds cnt", mk(ST_DWELL, 3'd7, 5'd5, 0, 0, 0));
    set_in(1, 1, 0, 1, 1, 0);
    exp_step("open_btn reloads", mk(ST_DWELL, 3'd7, 5'd0, 0, 0, 0));
    set_in(1, 1, 0, 0, 0, 0);
    dwell(1, 5);
    close_btn = 1'b1;
    exp_step("close_btn closes", mk(ST_CLOSING, 3'd7, 5'd0, 0, 0, 0));
    close_btn = 1'b0;
    closing(6, 0);
    exp_step("early endOpen", mk(ST_REL_D, 3'd0, 5'd0, 1, 0, 0));
    opendoor = 1'b0;
    exp_step("early idle", mk(ST_IDLE, 3'd0, 5'd0, 0, 0, 0));

    // Protocol violation in IDLE: fault sticks through a full door cycle.
    set_in(1, 1, 1, 0, 0, 0);
    exp_step("viol opening", mk(ST_OPENING, 3'd0, 5'd0, 0, 0, 1));
    mv2nxt = 1'b0;
    g_flt  = 1'b1;
    opening(1);
    dwell(1, 31);
    closing(7, 0);
    exp_step("viol endOpen", mk(ST_REL_D, 3'd0, 5'd0, 1, 0, 1));
    opendoor = 1'b0;
    exp_step("viol idle", mk(ST_IDLE, 3'd0, 5'd0, 0, 0, 1));
    switch = 1'b0;
    g_flt  = 1'b0;
    exp_step("switch clears fault", mk(ST_IDLE, 3'd0, 5'd0, 0, 0, 0));
    set_in(1, 1, 0, 0, 0, 0);
    exp_step("accept after switch", mk(ST_OPENING, 3'd0, 5'd0, 0, 0, 0));
    set_in(0, 0, 0, 0, 0, 0);
    exp_step("switch from opening", mk(ST_IDLE, 3'd0, 5'd0, 0, 0, 0));

    // Asynchronous reset mid-run at count 30, with fault set beforehand.
    set_in(1, 0, 1, 0, 0, 0);
    exp_step("run cnt0", mk(ST_RUN, 3'd0, 5'd0, 0, 0, 0));
    opendoor = 1'b1;
    exp_step("opendoor in run", mk(ST_RUN, 3'd0, 5'd0, 0, 0, 1));
    opendoor = 1'b0;
    for (int i = 2; i <= 30; i++)
      exp_step($sformatf("run cnt%0d", i), mk(ST_RUN, 3'd0, 5'd0, 0, 0, 1));
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset", got(), mk(ST_IDLE, 3'd0, 5'd0, 0, 0, 0));
    @(negedge clk);
    @(negedge clk);
    check("held in reset", got(), mk(ST_IDLE, 3'd0, 5'd0, 0, 0, 0));
    rst_n = 1'b1;
    run_cycle();
    mv2nxt = 1'b0;
    exp_step("post-reset idle", mk(ST_IDLE, 3'd0, 5'd0, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/door_run_timer.md
DOOR_RUN_TIMER -- requirements
Module: door_run_timer

Interface
REQ-001 clk  in  1  32 Hz system clock; all state changes on rising edge.
REQ-002 rst_n  in  1  reset, asynchronous, active-low.
REQ-003 switch  in  1  elevator master switch; 0 = synchronous clear.
REQ-004 opendoor  in  1  door-cycle request, level, held by controller until endOpen seen.
REQ-005 mv2nxt  in  1  move-one-floor request, level, held until endRun seen.
REQ-006 open_btn  in  1  cab door-open button.
REQ-007 close_btn  in  1  cab door-close button.
REQ-008 obstruct  in  1  door-edge obstruction sensor.
REQ-009 endOpen  out  1  one-cycle pulse: door cycle complete, door closed.
REQ-010 endRun  out  1  one-cycle pulse: one-floor travel complete.
REQ-011 DoorCount  out  5  dwell timer, 0..31.
REQ-012 door_pos  out  3  door position, 0 = closed, 7 = fully open.
REQ-013 tstate  out  3  current state code.
REQ-014 run_busy  out  1  high while in RUN.
REQ-015 fault  out  1  sticky protocol-violation flag.

Function
REQ-016 States SHALL be encoded as: IDLE 000, OPENING 001, DWELL 010, CLOSING 011, REL_D 100, RUN 101, REL_R 110; code 111 SHALL go to IDLE on the next edge.
REQ-017 IDLE: opendoor=1 SHALL go to OPENING with door_pos=0; otherwise mv2nxt=1 SHALL go to RUN with run count=0; opendoor has priority over mv2nxt.
REQ-018 OPENING: door_pos SHALL increment each edge; at the edge where door_pos==7, go to DWELL with DoorCount=0 (8 cycles total).
REQ-019 DWELL: DoorCount SHALL increment each edge; at the edge where DoorCount==31, go to CLOSING with door_pos held at 7 (32 cycles).
REQ-020 DWELL priority, highest first:
  - obstruct=1: hold DoorCount.
  - open_btn=1: reload DoorCount=0.
  - close_btn=1: go to CLOSING on the next edge.
REQ-021 CLOSING: door_pos SHALL decrement each edge; at the edge where door_pos==0, go to REL_D with endOpen=1.
REQ-022 CLOSING with obstruct=1 or open_btn=1 at an edge SHALL go to OPENING with door_pos+1; this overrides completion at door_pos==0, so no endOpen is issued.
REQ-023 Nominal latency: opendoor sampled at edge k gives endOpen high in the cycle after edge k+48.
REQ-024 RUN: an internal 6-bit run count SHALL increment each edge; at the edge where the count is 63, go to REL_R with endRun=1 (endRun after edge k+64).
REQ-025 endOpen/endRun SHALL be registered and high only in the first cycle of REL_D/REL_R, never re-pulsed.
REQ-026 REL_D SHALL stay until opendoor=0, then go to IDLE.
REQ-027 REL_R SHALL stay until mv2nxt=0, then go to IDLE.
REQ-028 In REL_D/REL_R, the other request line SHALL be ignored and SHALL NOT set fault.
REQ-029 fault SHALL set on any of:
  - opendoor=1 and mv2nxt=1 together in IDLE;
  - opendoor=1 in RUN;
  - mv2nxt=1 in OPENING, DWELL or CLOSING.
REQ-030 Violating requests SHALL be ignored (no state change).
REQ-031 fault SHALL clear only by reset or switch=0.
REQ-032 open_btn, close_btn and obstruct SHALL have no effect in IDLE, OPENING, RUN and the REL states.
REQ-033 DoorCount SHALL read 0 outside DWELL.
REQ-034 run_busy SHALL equal (tstate==RUN).

Reset
REQ-035 rst_n=0 SHALL immediately force every output to 0, tstate to IDLE and the run count to 0.
REQ-036 switch=0 at an edge SHALL force the same values as rst_n=0 from any state, overriding all other inputs.
REQ-037 After rst_n or switch release, the block SHALL accept requests from the first edge in IDLE.

Verification
REQ-038 Door cycle: opendoor=1 at edge 0, held until endOpen seen -> door_pos steps 0..7, DoorCount 0..31, door_pos steps 7..0, single endOpen after edge 48; opendoor low -> IDLE one edge later.
REQ-039 Run: mv2nxt=1 at edge 0 -> run_busy high 64 cycles, single endRun after edge 64; mv2nxt held 3 extra cycles -> no second pulse.
REQ-040 Reopen: obstruct pulse in CLOSING at door_pos=3 -> OPENING with door_pos=4, then DWELL from DoorCount=0; endOpen delayed accordingly.
REQ-041 Early close: close_btn at DoorCount=5 -> CLOSING next edge, endOpen 8 edges later; close_btn with obstruct together -> DoorCount held at 5.
REQ-042 Protocol violation: opendoor=1 and mv2nxt=1 together in IDLE -> OPENING, fault=1 and stays 1 through a full cycle; switch=0 for one edge -> fault=0, IDLE.
REQ-043 Asynchronous reset: rst_n low mid-RUN (count 30) -> all outputs 0 without a clock edge; after release, mv2nxt -> full 64-cycle run.
